id_issue_buffer: RTL and testbench

- Parametrised successor to the single-entry ID/issue pipeline register.
- Decoded instructions (scoreboard entries plus control-flow flag) from up to NrInPorts decoder lanes enter a Depth-entry in-order ring buffer.
- The buffer presents up to NrOutPorts oldest entries per cycle to the issue stage.
- Supports flush, lane-prefix handshakes and optional one-control-flow-per-cycle issue gating.

---
 rtl/id_issue_buffer_pkg.sv | 18 +
 rtl/id_issue_buffer_if.sv | 33 +++
 rtl/id_issue_buffer_prefix_count.sv | 23 ++
 rtl/id_issue_buffer.sv | 130 +++++++++++++
 tb/tb_id_issue_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_issue_buffer_pkg.sv
// id_issue_buffer_pkg
// Shared types for the ID/issue buffer:
//   scoreboard_entry_t - decoded instruction as produced by a decoder lane
//   id_buf_entry_t     - one buffer slot (decoded instruction + control-flow flag)
package id_issue_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } id_buf_entry_t;

endpackage

// File: rtl/id_issue_buffer_if.sv
// id_issue_buffer_if
// Decoder-side and issue-side handshake bundle of the ID/issue buffer.
//   in_entry_i / in_ctrl_flow_i / in_valid_i : decoder lanes, lane 0 oldest
//   in_ready_o                               : per-lane acceptance
//   out_entry_o / out_ctrl_flow_o / out_valid_o : oldest entries to issue
//   out_ack_i                                : issue consumed lanes (prefix)
// Modports: slave = buffer, master = surrounding decode/issue logic.
interface id_issue_buffer_if #(
    parameter int unsigned NrInPorts  = 2,
    parameter int unsigned NrOutPorts = 1
);
    import id_issue_buffer_pkg::*;

    scoreboard_entry_t [NrInPorts-1:0]  in_entry_i;
    logic              [NrInPorts-1:0]  in_ctrl_flow_i;
    logic              [NrInPorts-1:0]  in_valid_i;
    logic              [NrInPorts-1:0]  in_ready_o;
    scoreboard_entry_t [NrOutPorts-1:0] out_entry_o;
    logic              [NrOutPorts-1:0] out_ctrl_flow_o;
    logic              [NrOutPorts-1:0] out_valid_o;
    logic              [NrOutPorts-1:0] out_ack_i;

    modport slave (
        input  in_entry_i, in_ctrl_flow_i, in_valid_i, out_ack_i,
        output in_ready_o, out_entry_o, out_ctrl_flow_o, out_valid_o
    );

    modport master (
        output in_entry_i, in_ctrl_flow_i, in_valid_i, out_ack_i,
        input  in_ready_o, out_entry_o, out_ctrl_flow_o, out_valid_o
    );

endinterface

// File: rtl/id_issue_buffer_prefix_count.sv
// id_prefix_count
// Counts the run of consecutive ones starting at bit 0 of vec_i.
//   vec_i   : N-bit input vector
//   count_o : number of leading ones from bit 0 ($clog2(N+1) bits)
module id_prefix_count #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]           vec_i,
    output logic [$clog2(N+1)-1:0] count_o
);
    localparam int unsigned CW = $clog2(N + 1);

    always_comb begin
        logic run;
        run     = 1'b1;
        count_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            run = run & vec_i[i];
            if (run) count_o = count_o + CW'(1);
        end
    end

endmodule

// File: rtl/id_issue_buffer.sv
// id_issue_buffer
// In-order ring buffer between decode and issue. Up to NrInPorts decoded
// instructions are written per cycle, up to NrOutPorts oldest are presented.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : drop all buffered entries (effective next cycle)
//   bus          : decoder/issue handshake (slave side)
//   usage_o      : registered occupancy
module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int unsigned NrInPorts           = 2,
    parameter int unsigned NrOutPorts          = 1,
    parameter int unsigned Depth               = 4,
    parameter bit          SingleCtrlFlowIssue = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    id_issue_buffer_if.slave           bus,
    output logic [$clog2(Depth+1)-1:0] usage_o
);
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned PushW = $clog2(NrInPorts + 1);
    localparam int unsigned PopW  = $clog2(NrOutPorts + 1);
    localparam logic [PtrW-1:0] PtrMask = PtrW'(Depth - 1);

    if ((Depth == 0) || ((Depth & (Depth - 1)) != 0) ||
        (Depth < NrInPorts) || (Depth < NrOutPorts)) begin : g_bad_params
        $fatal(1, "id_issue_buffer: Depth must be a power of two >= max(NrInPorts, NrOutPorts)");
    end

    id_buf_entry_t         mem_q [Depth];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PushW-1:0]      n_push;
    logic [PopW-1:0]       n_pop;
    logic [CntW:0]         free;
    logic [NrInPorts-1:0]  in_ready, push_req;
    logic [NrOutPorts-1:0] out_valid, pop_req;

    // Presentation from registered state only; a control-flow entry hides
    // every younger lane when single control-flow issue is enabled.
    always_comb begin
        logic            cf_seen;
        logic [PtrW-1:0] idx;
        cf_seen             = 1'b0;
        idx                 = '0;
        out_valid           = '0;
        bus.out_entry_o     = '0;
        bus.out_ctrl_flow_o = '0;
        for (int unsigned j = 0; j < NrOutPorts; j++) begin
            idx                    = (rd_ptr_q + PtrW'(j)) & PtrMask;
            bus.out_entry_o[j]     = mem_q[idx].sbe;
            bus.out_ctrl_flow_o[j] = mem_q[idx].is_ctrl_flow;
            out_valid[j]           = (count_q > CntW'(j)) && !(SingleCtrlFlowIssue && cf_seen);
            cf_seen                = cf_seen | mem_q[idx].is_ctrl_flow;
        end
    end

    assign bus.out_valid_o = out_valid;
    assign pop_req         = bus.out_ack_i & out_valid;

    id_prefix_count #(.N(NrOutPorts)) u_pop_count (
        .vec_i   (pop_req),
        .count_o (n_pop)
    );

    // Slots freed by this cycle's pops are offered to the decoder immediately.
    assign free = (CntW+1)'(Depth) - (CntW+1)'(count_q) + (CntW+1)'(n_pop);

    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < NrInPorts; k++) begin
            in_ready[k] = !rst_i && !flush_i && (free > (CntW+1)'(k));
        end
    end

    assign bus.in_ready_o = in_ready;
    assign push_req       = bus.in_valid_i & in_ready;

    id_prefix_count #(.N(NrInPorts)) u_push_count (
        .vec_i   (push_req),
        .count_o (n_push)
    );

    always_comb begin
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = (rd_ptr_q + PtrW'(n_pop)) & PtrMask;
            wr_ptr_d = (wr_ptr_q + PtrW'(n_push)) & PtrMask;
            count_d  = count_q + CntW'(n_push) - CntW'(n_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NrInPorts; k++) begin
            if (PushW'(k) < n_push) begin
                mem_q[(wr_ptr_q + PtrW'(k)) & PtrMask] <= '{sbe: bus.in_entry_i[k],
                                                           is_ctrl_flow: bus.in_ctrl_flow_i[k]};
            end
        end
    end

    assign usage_o = count_q;

    a_in_valid_prefix : assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.in_valid_i & (bus.in_valid_i + NrInPorts'(1))) == '0);
    a_ack_prefix : assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.out_ack_i & (bus.out_ack_i + NrOutPorts'(1))) == '0);
    a_ack_on_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.out_ack_i & ~out_valid) == '0);

endmodule

// File: tb/tb_id_issue_buffer.sv
// tb_id_issue_buffer
// Directed stimulus against id_issue_buffer (Depth 4, 2 in, 2 out, single
// control-flow issue) with a queue-based reference model and literal checks.
module tb_id_issue_buffer;
    import id_issue_buffer_pkg::*;

    localparam int unsigned NI = 2;
    localparam int unsigned NO = 2;
    localparam int unsigned D  = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_i = 1'b0;
    logic [2:0] usage_o;
    bit         run = 1'b0;

    int checks = 0;
    int errors = 0;
    int nid = 0;
    int base = 0;

    id_buf_entry_t q[$];

    always #5 clk = ~clk;

    id_issue_buffer_if #(.NrInPorts(NI), .NrOutPorts(NO)) bus ();

    id_issue_buffer #(
        .NrInPorts           (NI),
        .NrOutPorts          (NO),
        .Depth               (D),
        .SingleCtrlFlowIssue (1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus),
        .usage_o (usage_o)
    );

    function automatic scoreboard_entry_t mk(input int id);
        scoreboard_entry_t e;
        e.pc = 32'h1000 + 32'(id) * 32'd4;
        e.op = 7'(id);
        e.rd = 5'(id + 3);
        return e;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Oldest entries are valid in order; nothing behind a control-flow entry.
    function automatic logic [NO-1:0] m_valid();
        logic [NO-1:0] v;
        bit blocked;
        v = '0;
        blocked = 1'b0;
        for (int j = 0; j < NO; j++) begin
            if (j < q.size()) begin
                if (!blocked) v[j] = 1'b1;
                if (q[j].is_ctrl_flow) blocked = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic int m_npop(input logic [NO-1:0] ack);
        logic [NO-1:0] v;
        int n;
        v = m_valid();
        n = 0;
        for (int j = 0; j < NO; j++) begin
            if (ack[j] && v[j] && n == j) n++;
        end
        return n;
    endfunction

    function automatic logic [NI-1:0] m_ready(input logic [NO-1:0] ack, input logic fl);
        logic [NI-1:0] r;
        int fr;
        fr = D - q.size() + m_npop(ack);
        for (int k = 0; k < NI; k++) r[k] = !fl && (fr > k);
        return r;
    endfunction

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (run && !rst_i) begin
            logic [NO-1:0] ev;
            ev = m_valid();
            chk("model usage", 64'(usage_o), 64'(q.size()));
            chk("model out_valid", 64'(bus.out_valid_o), 64'(ev));
            for (int j = 0; j < NO; j++) begin
                if (ev[j]) begin
                    chk("model out_entry", 64'(bus.out_entry_o[j]), 64'(q[j].sbe));
                    chk("model out_ctrl_flow", 64'(bus.out_ctrl_flow_o[j]), 64'(q[j].is_ctrl_flow));
                end
            end
            chk("model in_ready", 64'(bus.in_ready_o), 64'(m_ready(bus.out_ack_i, flush_i)));
        end
    end

    // Model state update at the active edge.
    always @(posedge clk) begin
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            int np;
            logic [NI-1:0] r;
            bit go;
            np = m_npop(bus.out_ack_i);
            r  = m_ready(bus.out_ack_i, 1'b0);
            for (int n = 0; n < np; n++) void'(q.pop_front());
            go = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (go && bus.in_valid_i[k] && r[k])
                    q.push_back('{sbe: bus.in_entry_i[k], is_ctrl_flow: bus.in_ctrl_flow_i[k]});
                else
                    go = 1'b0;
            end
        end
    end

    // Drive one cycle; ack is limited to lanes the model says are valid.
    task automatic drive(input logic [NI-1:0] v, input logic [NI-1:0] cf,
                         input logic [NO-1:0] ack, input logic fl);
        @(posedge clk);
        #1;
        base = nid;
        for (int k = 0; k < NI; k++) begin
            bus.in_entry_i[k] = mk(nid);
            nid++;
        end
        bus.in_ctrl_flow_i = cf;
        bus.in_valid_i     = v;
        bus.out_ack_i      = ack & m_valid();
        flush_i            = fl;
        @(negedge clk);
    endtask

    logic [1:0] vt [16] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11, 2'b11,
                            2'b00, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    logic [1:0] at [16] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11,
                            2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [1:0] ct [16] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10,
                            2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    initial begin
        int ida, idc, ide, idx, ids;
        bus.in_entry_i     = '0;
        bus.in_ctrl_flow_i = '0;
        bus.in_valid_i     = '0;
        bus.out_ack_i      = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        run   = 1'b1;

        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("reset usage", 64'(usage_o), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready_o), 64'b11);

        drive(2'b11, 2'b00, 2'b00, 1'b0); ida = base;
        drive(2'b11, 2'b00, 2'b00, 1'b0); idc = base;
        chk("push2 usage", 64'(usage_o), 64'd2);
        chk("push2 entry0 A", 64'(bus.out_entry_o[0]), 64'(mk(ida)));
        chk("push2 out_valid", 64'(bus.out_valid_o), 64'b11);

        drive(2'b11, 2'b00, 2'b00, 1'b0);
        chk("full usage", 64'(usage_o), 64'd4);
        chk("full in_ready", 64'(bus.in_ready_o), 64'b00);

        drive(2'b11, 2'b00, 2'b01, 1'b0); ide = base;
        chk("full+ack in_ready", 64'(bus.in_ready_o), 64'b01);

        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("after ack usage", 64'(usage_o), 64'd4);
        chk("after ack entry0 B", 64'(bus.out_entry_o[0]), 64'(mk(ida + 1)));
        chk("after ack entry1 C", 64'(bus.out_entry_o[1]), 64'(mk(idc)));

        drive(2'b00, 2'b00, 2'b11, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("wrap entry0 D", 64'(bus.out_entry_o[0]), 64'(mk(idc + 1)));
        chk("wrap entry1 E", 64'(bus.out_entry_o[1]), 64'(mk(ide)));
        drive(2'b00, 2'b00, 2'b11, 1'b0);

        drive(2'b11, 2'b01, 2'b00, 1'b0); idx = base;
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("cf out_valid", 64'(bus.out_valid_o), 64'b01);
        chk("cf entry0 X", 64'(bus.out_entry_o[0]), 64'(mk(idx)));
        chk("cf flag0", 64'(bus.out_ctrl_flow_o[0]), 64'd1);
        drive(2'b00, 2'b00, 2'b01, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("after cf entry0 Y", 64'(bus.out_entry_o[0]), 64'(mk(idx + 1)));
        chk("after cf out_valid", 64'(bus.out_valid_o), 64'b01);

        drive(2'b11, 2'b00, 2'b01, 1'b0);
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        drive(2'b11, 2'b00, 2'b11, 1'b1);
        chk("flush usage", 64'(usage_o), 64'd3);
        chk("flush in_ready", 64'(bus.in_ready_o), 64'b00);
        drive(2'b11, 2'b00, 2'b00, 1'b0); ids = base;
        chk("post flush usage", 64'(usage_o), 64'd0);
        chk("post flush out_valid", 64'(bus.out_valid_o), 64'b00);
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("post flush entry0 S", 64'(bus.out_entry_o[0]), 64'(mk(ids)));
        chk("post flush entry1 T", 64'(bus.out_entry_o[1]), 64'(mk(ids + 1)));

        for (int i = 0; i < 16; i++) drive(vt[i], ct[i], at[i], 1'b0);

        for (int i = 0; i < 8 && q.size() > 0; i++) drive(2'b00, 2'b00, 2'b11, 1'b0);
        drive(2'b11, 2'b00, 2'b00, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("pre reset usage", 64'(usage_o), 64'd2);

        @(posedge clk);
        #1;
        bus.in_valid_i = '0;
        bus.out_ack_i  = '0;
        #2 rst_i = 1'b1;
        #1;
        chk("async reset usage", 64'(usage_o), 64'd0);
        chk("async reset out_valid", 64'(bus.out_valid_o), 64'b00);
        chk("async reset in_ready", 64'(bus.in_ready_o), 64'b00);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("after reset in_ready", 64'(bus.in_ready_o), 64'b11);
        chk("after reset usage", 64'(usage_o), 64'd0);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
